// File: rtl/bio_ext.sv
// Board I/O block: switches, keys, LEDs and 7-seg digits behind a 4-register bus map with key-event IRQ.
// Optional key debouncing is enabled by defining BIO_DEBOUNCE_EN.
`timescale 1ns/1ps
module bio_ext #(
    parameter int unsigned NUM_SW    = 18,
    parameter int unsigned NUM_KEY   = 3,
    parameter int unsigned NUM_LEDG  = 9,
    parameter int unsigned NUM_LEDR  = 18,
    parameter int unsigned NUM_HEX   = 8,
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   wr,
    input  logic [1:0]             addr,
    input  logic [31:0]            din,
    output logic [31:0]            dout,
    input  logic [NUM_SW-1:0]      sw_in,
    input  logic [NUM_KEY-1:0]     key_in_n,
    output logic [NUM_LEDG-1:0]    led_g,
    output logic [NUM_LEDR-1:0]    led_r,
    output logic [7*NUM_HEX-1:0]   hex_n,
    output logic                   irq
);

    localparam int unsigned SEG_W = 7;

    logic [NUM_SW-1:0]   r_sw_p;
    logic [NUM_SW-1:0]   r_sw_s;
    logic [NUM_KEY-1:0]  r_key_p;
    logic [NUM_KEY-1:0]  r_key_s;
    logic [NUM_KEY-1:0]  r_key_prev;
    logic [NUM_KEY-1:0]  r_key_evt;
    logic                r_irq_en;
    logic [NUM_LEDG-1:0] r_led_g;
    logic [NUM_LEDR-1:0] r_led_r;
    logic [SEG_W-1:0]    r_hex [NUM_HEX];

    logic                w_wr_en;
    logic [2:0]          w_hex_idx;
    logic [NUM_KEY-1:0]  w_key_lvl;
    logic [NUM_KEY-1:0]  w_w1c;
    logic [NUM_KEY-1:0]  w_key_rise;
    logic [NUM_HEX-1:0]  w_nonblank;
    logic                w_unused;

    assign w_wr_en    = en & wr;
    assign w_hex_idx  = din[18:16];
    assign w_w1c      = (w_wr_en && addr == 2'd1) ? din[16 +: NUM_KEY] : '0;
    assign w_key_rise = w_key_lvl & ~r_key_prev;
    assign w_unused   = ^din;

    // Two-flop synchronisers; keys are inverted to active-high first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_p  <= '0;
            r_sw_s  <= '0;
            r_key_p <= '0;
            r_key_s <= '0;
        end else begin
            r_sw_p  <= sw_in;
            r_sw_s  <= r_sw_p;
            r_key_p <= ~key_in_n;
            r_key_s <= r_key_p;
        end
    end

`ifdef BIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    logic [CNT_W-1:0]   r_db_cnt [NUM_KEY];
    logic [NUM_KEY-1:0] r_key_lvl;

    // A key level flips only after DB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_lvl <= '0;
            for (int i = 0; i < int'(NUM_KEY); i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_KEY); i++) begin
                if (r_key_s[i] != r_key_lvl[i]) begin
                    if (r_db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                        r_key_lvl[i] <= ~r_key_lvl[i];
                        r_db_cnt[i]  <= '0;
                    end else begin
                        r_db_cnt[i]  <= r_db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_key_lvl = r_key_lvl;
`else
    assign w_key_lvl = r_key_s;
`endif

    // Press events: a concurrent set overrides the write-1-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_prev <= '0;
            r_key_evt  <= '0;
            r_irq_en   <= 1'b0;
        end else begin
            r_key_prev <= w_key_lvl;
            r_key_evt  <= (r_key_evt & ~w_w1c) | w_key_rise;
            if (w_wr_en && addr == 2'd1) r_irq_en <= din[31];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led_g <= '0;
            r_led_r <= '0;
            for (int i = 0; i < int'(NUM_HEX); i++) r_hex[i] <= '1;
        end else if (w_wr_en) begin
            case (addr)
                2'd0: r_led_g <= din[NUM_LEDG-1:0];
                2'd2: r_led_r <= din[NUM_LEDR-1:0];
                2'd3: begin
                    for (int i = 0; i < int'(NUM_HEX); i++)
                        if (w_hex_idx == 3'(i)) r_hex[i] <= ~din[SEG_W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hex_n      = '1;
        w_nonblank = '0;
        for (int i = 0; i < int'(NUM_HEX); i++) begin
            hex_n[SEG_W*i +: SEG_W] = r_hex[i];
            w_nonblank[i]           = ~&r_hex[i];
        end
    end

    // Read mux is combinational and side-effect free.
    always_comb begin
        dout = '0;
        case (addr)
            2'd0: dout = 32'(r_sw_s);
            2'd1: begin
                dout[31]             = r_irq_en;
                dout[16 +: NUM_KEY]  = r_key_evt;
                dout[8]              = rst;
                dout[NUM_KEY-1:0]    = w_key_lvl;
            end
            2'd2: dout = 32'(r_led_r);
            default: dout = 32'(w_nonblank);
        endcase
    end

    assign led_g = r_led_g;
    assign led_r = r_led_r;
    assign irq   = r_irq_en & (|r_key_evt);

endmodule

// File: tb/tb_bio_ext.sv
// Self-checking bench for bio_ext: directed and randomized bus/pin stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_bio_ext;

    localparam int unsigned NSW  = 18;
    localparam int unsigned NKEY = 3;
    localparam int unsigned NLG  = 9;
    localparam int unsigned NLR  = 18;
    localparam int unsigned NHEX = 8;
    localparam int unsigned DB   = 4;
`ifdef BIO_DEBOUNCE_EN
    localparam int unsigned KLAT = DB + 2;
`else
    localparam int unsigned KLAT = 2;
`endif

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic                 wr;
    logic [1:0]           addr;
    logic [31:0]          din;
    logic [31:0]          dout;
    logic [NSW-1:0]       sw_in;
    logic [NKEY-1:0]      key_in_n;
    logic [NLG-1:0]       led_g;
    logic [NLR-1:0]       led_r;
    logic [7*NHEX-1:0]    hex_n;
    logic                 irq;

    bio_ext #(
        .NUM_SW(NSW), .NUM_KEY(NKEY), .NUM_LEDG(NLG), .NUM_LEDR(NLR),
        .NUM_HEX(NHEX), .DB_CYCLES(DB)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .din(din), .dout(dout),
        .sw_in(sw_in), .key_in_n(key_in_n), .led_g(led_g), .led_r(led_r),
        .hex_n(hex_n), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [NLG-1:0]  m_led_g;
    logic [NLR-1:0]  m_led_r;
    logic [6:0]      m_hex [NHEX];
    logic [NSW-1:0]  m_sw;
    logic            m_irq_en;
    logic [NKEY-1:0] m_evt;
    logic [NKEY-1:0] m_lvl;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        addr = a; din = d; en = 1'b1; wr = 1'b1;
        tick();
        en = 1'b0; wr = 1'b0; din = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic m_reset();
        m_led_g = '0; m_led_r = '0; m_sw = '0;
        m_irq_en = 1'b0; m_evt = '0; m_lvl = '0;
        for (int i = 0; i < int'(NHEX); i++) m_hex[i] = 7'h7F;
    endtask

    function automatic logic [7*NHEX-1:0] exp_hex();
        logic [7*NHEX-1:0] r;
        for (int i = 0; i < int'(NHEX); i++) r[7*i +: 7] = m_hex[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_a1();
        logic [31:0] r;
        r = '0;
        r[31] = m_irq_en;
        r[16 +: NKEY] = m_evt;
        r[8] = rst;
        r[NKEY-1:0] = m_lvl;
        return r;
    endfunction

    function automatic logic [31:0] exp_a3();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < int'(NHEX); i++) r[i] = (m_hex[i] != 7'h7F);
        return r;
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, "_led_g"}, 64'(led_g), 64'(m_led_g));
        chk({tag, "_led_r"}, 64'(led_r), 64'(m_led_r));
        chk({tag, "_hex_n"}, 64'(hex_n), 64'(exp_hex()));
        chk({tag, "_irq"},   64'(irq),   64'(m_irq_en & (|m_evt)));
    endtask

    task automatic chk_a1(input string tag);
        logic [31:0] d;
        rd(2'd1, d);
        chk(tag, 64'(d), 64'(exp_a1()));
        chk({tag, "_irq"}, 64'(irq), 64'(m_irq_en & (|m_evt)));
    endtask

    initial begin
        logic [31:0] d;
        logic [NSW-1:0] sv;
        logic [NKEY-1:0] km;
        logic [2:0] idx;
        logic [6:0] seg;
        logic ie;

        rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
        sw_in = '0; key_in_n = '1;
        m_reset();

        // Reset state
        tick();
        chk_outputs("reset");
        rd(2'd1, d);
        chk("reset_a1", 64'(d), 64'h0000_0100);
        rd(2'd0, d);
        chk("reset_a0", 64'(d), 64'h0);
        rst = 1'b0;
        tick();
        chk_a1("idle_a1");

        // Directed LED and digit writes
        wr_reg(2'd0, 32'h1A5);      m_led_g = 9'h1A5;
        wr_reg(2'd2, 32'h3FFFF);    m_led_r = 18'h3FFFF;
        rd(2'd2, d);
        chk("led_r_read", 64'(d), 64'h3FFFF);
        chk_outputs("led_dir");
        wr_reg(2'd3, 32'h0005_003F); m_hex[5] = 7'h40;
        chk("hex5_seg", 64'(hex_n[41:35]), 64'h40);
        chk_outputs("hex_dir");
        rd(2'd3, d);
        chk("hex_flags", 64'(d), 64'(exp_a3()));

        // Randomized register/switch traffic
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    d = $urandom; m_led_g = d[NLG-1:0];
                    wr_reg(2'd0, d);
                end
                1: begin
                    d = $urandom; m_led_r = d[NLR-1:0];
                    wr_reg(2'd2, d);
                    rd(2'd2, d);
                    chk("rand_led_r_rd", 64'(d), 64'(m_led_r));
                end
                2: begin
                    idx = 3'($urandom); seg = 7'($urandom);
                    m_hex[idx] = ~seg;
                    wr_reg(2'd3, {13'b0, idx, 9'($urandom), seg});
                    rd(2'd3, d);
                    chk("rand_hex_flags", 64'(d), 64'(exp_a3()));
                end
                default: begin
                    sv = NSW'($urandom);
                    sw_in = sv;
                    tick();
                    rd(2'd0, d);
                    chk("sw_not_yet", 64'(d), 64'(m_sw));
                    tick();
                    m_sw = sv;
                    rd(2'd0, d);
                    chk("sw_synced", 64'(d), 64'(m_sw));
                end
            endcase
            chk_outputs("rand");
        end

        // Key press -> level -> event -> irq, then W1C
        wr_reg(2'd1, 32'h8000_0000); m_irq_en = 1'b1;
        chk_a1("irq_en_set");
        key_in_n[1] = 1'b0;
        tick(KLAT - 1);
        chk_a1("k1_lvl_early");
        tick();
        m_lvl = 3'b010;
        chk_a1("k1_lvl");
        tick();
        m_evt = 3'b010;
        chk_a1("k1_evt");
        wr_reg(2'd1, 32'h8002_0000); m_evt = 3'b000;
        chk_a1("k1_w1c");
        key_in_n[1] = 1'b1;
        tick(KLAT + 2);
        m_lvl = '0;
        chk_a1("k1_release");

        // Event set in the same edge as its W1C: set wins
        key_in_n[0] = 1'b0;
        tick(KLAT);
        m_lvl = 3'b001;
        chk_a1("k0_before_set");
        wr_reg(2'd1, 32'h8001_0000); m_evt = 3'b001;
        chk_a1("k0_set_wins");
        key_in_n[0] = 1'b1;
        tick(KLAT + 2);
        m_lvl = '0;
        wr_reg(2'd1, 32'h8001_0000); m_evt = '0;
        chk_a1("k0_cleared");

        // Randomized key press groups with random W1C / enable writes
        for (int it = 0; it < 6; it++) begin
            km = NKEY'($urandom_range(1, 7));
            key_in_n = ~km;
            tick(KLAT + 1);
            m_evt |= km & ~m_lvl;
            m_lvl = km;
            chk_a1("rkey_press");
            km = NKEY'($urandom); ie = 1'($urandom);
            wr_reg(2'd1, {ie, 12'b0, km, 16'b0});
            m_irq_en = ie; m_evt &= ~km;
            chk_a1("rkey_w1c");
            key_in_n = '1;
            tick(KLAT + 2);
            m_lvl = '0;
            chk_a1("rkey_release");
        end
        wr_reg(2'd1, 32'h8007_0000); m_irq_en = 1'b1; m_evt = '0;

`ifdef BIO_DEBOUNCE_EN
        // Short glitch is filtered, a held press is accepted after DB_CYCLES+2 edges
        key_in_n[2] = 1'b0;
        tick(3);
        key_in_n[2] = 1'b1;
        tick(8);
        chk_a1("db_glitch");
        key_in_n[2] = 1'b0;
        tick(DB + 1);
        chk_a1("db_early");
        tick();
        m_lvl = 3'b100;
        chk_a1("db_lvl");
        tick();
        m_evt = 3'b100;
        chk_a1("db_evt");
        key_in_n[2] = 1'b1;
        tick(KLAT + 2);
        m_lvl = '0;
`endif

        // Mid-operation reset discards state and pending events
        wr_reg(2'd0, 32'h0FF); m_led_g = 9'h0FF;
        wr_reg(2'd3, 32'h0002_0011); m_hex[2] = ~7'h11;
        key_in_n[0] = 1'b0;
        tick(KLAT + 1);
        m_lvl = 3'b001; m_evt |= 3'b001;
        chk_a1("pre_rst_evt");
        key_in_n = '1;
        rst = 1'b1;
        tick();
        m_reset();
        chk_outputs("mid_rst");
        rd(2'd1, d);
        chk("mid_rst_a1", 64'(d), 64'h0000_0100);
        rst = 1'b0;
        tick(KLAT + 2);
        chk_a1("post_rst_a1");
        chk_outputs("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
